// File: rtl/mcpu_soc_mmio_bridge.sv
// mcpu_soc_mmio_bridge: registered front end between the core memory pipeline
// and the combinational MMIO decoder. One request in flight at a time; the
// decoder bus is driven from holding registers so addresses never glitch and
// write strobes last exactly one cycle.
// Optional build macro: MCPU_MMIO_UNMAPPED_EN (requests above page 6 are
// blocked and reported on mmio2core_err).
//
// state  | meaning
// IDLE   | ready; a valid request is latched and accepted
// ACCESS | decoder sees the latched request; only state with write strobe
// WAIT   | read address held while decoder data settles (cnt counts down)
// RESP   | read data returned to the core for one cycle
module mcpu_soc_mmio_bridge #(
  parameter int READ_WAIT = 1
) (
  input  logic        clkrst_core_clk,
  input  logic        clkrst_core_rst_n,
  input  logic        core2mmio_valid,
  input  logic [30:2] core2mmio_addr,
  input  logic [31:0] core2mmio_wdata,
  input  logic [3:0]  core2mmio_wmask,
  output logic        core2mmio_stall,
  output logic        mmio2core_rvalid,
  output logic [31:0] mmio2core_rdata,
  output logic        mmio2core_err,
  output logic [30:2] mmio_addr,
  output logic [31:0] mmio_data_in,
  output logic [3:0]  mmio_wren,
  input  logic [31:0] mmio_data_out
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [30:2] r_addr_q;
  logic [31:0] r_wdata_q;
  logic [3:0]  r_wmask_q;
  logic [31:0] r_rdata_q;
  logic [3:0]  r_cnt;
  logic        w_accept;
  logic        w_capture;
  logic        w_unmapped;

  assign w_accept = (r_state == S_IDLE) && core2mmio_valid;

`ifdef MCPU_MMIO_UNMAPPED_EN
  logic r_unmapped;

  // Classify the request at acceptance so the decision is stable for the whole transaction
  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      r_unmapped <= 1'b0;
    end else if (w_accept) begin
      r_unmapped <= (core2mmio_addr[30:12] > 19'd6);
    end
  end

  assign w_unmapped    = r_unmapped;
  assign mmio2core_err = r_unmapped &&
                         (((r_state == S_ACCESS) && (r_wmask_q != 4'h0)) ||
                          (r_state == S_RESP));
`else
  assign w_unmapped    = 1'b0;
  assign mmio2core_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and read-data capture strobe
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (core2mmio_valid) w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (r_wmask_q != 4'h0) begin
          w_state_nxt = S_IDLE;
        end else if (READ_WAIT == 0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Holding registers: written only on acceptance so the decoder bus stays put
  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      r_addr_q  <= '0;
      r_wdata_q <= '0;
      r_wmask_q <= '0;
    end else if (w_accept) begin
      r_addr_q  <= core2mmio_addr;
      r_wdata_q <= core2mmio_wdata;
      r_wmask_q <= core2mmio_wmask;
    end
  end

  // Read wait down-counter; terminal count 1 marks the capture cycle
  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      r_cnt <= 4'd0;
    end else if ((r_state == S_ACCESS) && (r_wmask_q == 4'h0)) begin
      r_cnt <= 4'(READ_WAIT);
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Read data capture; unmapped reads return zero
  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      r_rdata_q <= '0;
    end else if (w_capture) begin
      r_rdata_q <= w_unmapped ? 32'h0 : mmio_data_out;
    end
  end

  assign core2mmio_stall  = (r_state != S_IDLE);
  assign mmio2core_rvalid = (r_state == S_RESP);
  assign mmio2core_rdata  = r_rdata_q;
  assign mmio_addr        = r_addr_q;
  assign mmio_data_in     = r_wdata_q;
  assign mmio_wren        = ((r_state == S_ACCESS) && !w_unmapped) ? r_wmask_q : 4'h0;

endmodule

// File: doc/mcpu_soc_mmio_bridge.md
# mcpu_soc_mmio_bridge

Sequential front end for the SoC MMIO decoder. Accepts one core load/store at a time on a valid/stall handshake and registers it. Drives the decoder's combinational `addr`/`data_in`/`wren` bus with stable values, and for reads waits a fixed number of cycles before capturing `data_out`. Sits between the core memory pipeline and the MMIO decoder. Guarantees exactly-one-cycle write strobes and glitch-free addresses for side-effecting peripheral reads.

## Interface
Parameters:
- `READ_WAIT`, default 1: cycles the address is held after the access cycle before read data is captured; legal range 0..15.

Ports:
- `clkrst_core_clk`  in  1  core clock; all logic is on the rising edge.
- `clkrst_core_rst_n`  in  1  asynchronous, active-low reset.
- `core2mmio_valid`  in  1  request present.
- `core2mmio_addr`  in  [30:2]  word address.
- `core2mmio_wdata`  in  32  store data.
- `core2mmio_wmask`  in  4  byte enables; `4'h0` means read.
- `core2mmio_stall`  out  1  request not accepted this cycle.
- `mmio2core_rvalid`  out  1  read data valid, single-cycle pulse.
- `mmio2core_rdata`  out  32  read data.
- `mmio2core_err`  out  1  unmapped-access pulse; tied 0 unless `MCPU_MMIO_UNMAPPED_EN` is defined.
- `mmio_addr`  out  [30:2]  to decoder `addr`.
- `mmio_data_in`  out  32  to decoder `data_in`.
- `mmio_wren`  out  4  to decoder `wren`.
- `mmio_data_out`  in  32  from decoder `data_out`.

## Operation
- States are IDLE, ACCESS, WAIT and RESP.
- Holding registers: `addr_q`, `wdata_q`, `wmask_q`. `mmio_addr = addr_q` and `mmio_data_in = wdata_q` at all times.
- IDLE:
  - `core2mmio_stall = 0`.
  - On `core2mmio_valid`, latch addr/wdata/wmask and go to ACCESS.
- ACCESS, exactly one cycle:
  - `mmio_wren = wmask_q`; this is the only state in which `mmio_wren` may be nonzero.
  - Write (`wmask_q != 0`): go to IDLE. Writes are posted and produce no response.
  - Read with `READ_WAIT == 0`: capture `mmio_data_out` into `rdata_q` at the end of the cycle and go to RESP.
  - Read with `READ_WAIT > 0`: load `cnt = READ_WAIT` and go to WAIT.
- WAIT:
  - Decrement `cnt` each cycle.
  - In the cycle with `cnt == 1`, capture `mmio_data_out` and go to RESP.
  - `cnt` width is 4 bits.
- RESP: `mmio2core_rvalid = 1` for one cycle, then go to IDLE.
- `core2mmio_stall` is combinational `(state != IDLE)`. A request presented while stalled is not sampled; the core holds it.
- `mmio_addr` keeps the last address after a transaction ends. It never returns to 0 except on reset, so no spurious decode of page 0 occurs.
- `mmio2core_rdata = rdata_q`. It holds its value until the next capture and is don't-care when `rvalid = 0`.

## Timing
- Reset values:
  - state IDLE, `addr_q = 0`, `wdata_q = 0`, `wmask_q = 0`, `rdata_q = 0`, `cnt = 0`.
  - Outputs: `mmio_wren = 0`, `mmio2core_rvalid = 0`, `mmio2core_err = 0`, `core2mmio_stall = 0`.
- Latency is counted from the acceptance cycle c0 (valid high in IDLE):
  - Write: `mmio_wren` is asserted in c1.
  - Read: `mmio2core_rvalid` is asserted in c(2+READ_WAIT).
- Throughput:
  - Writes: one per 2 cycles.
  - Reads: one per 3+READ_WAIT cycles.
  - A new request can be accepted in the cycle right after RESP or right after a write's ACCESS.
- Reset asserted mid-transaction: the transaction is dropped.
  - No `rvalid` pulse and no write strobe after reset.
  - A write whose ACCESS cycle was cut short by reset may or may not have reached the peripheral.

## Configuration
- `MCPU_MMIO_UNMAPPED_EN` defined: a request with `addr[30:12] > 6` is unmapped.
  - Unmapped write: `mmio_wren` is forced to 0 in ACCESS and `mmio2core_err` pulses in c1.
  - Unmapped read: RESP returns `32'h0` with `mmio2core_err = 1` in the same cycle as `rvalid`.
  - Handshake timing is unchanged.
- Undefined: every address is passed through unchanged and captured data is whatever the decoder drives. `mmio2core_err` is constant 0.

## Test plan
- Write: addr 0x0000_0400>>2, wdata 0x1234_5678, wmask 4'hF -> `mmio_wren = 4'hF` for exactly one cycle (c1) with `mmio_data_in = 0x12345678`; stall high in c1 only.
- Read with READ_WAIT=1: `mmio_data_out` changes to 0xCAFE_F00D in c2 -> `rvalid` in c3 with rdata 0xCAFEF00D; `mmio_addr` stable c1..c3 and after.
- READ_WAIT=0 and READ_WAIT=15: `rvalid` in c2 and c17 respectively, each exactly one cycle; `mmio_wren = 0` throughout.
- Valid held high continuously with write, read, write -> accepted at c0, c2, c6 (READ_WAIT=1); no request lost or duplicated.
- Reset pulsed in WAIT -> no `rvalid` afterwards; all outputs at reset values; next request accepted normally.
- With `MCPU_MMIO_UNMAPPED_EN`, addr page 7:
  - Write -> `mmio_wren = 0` and err pulse in c1.
  - Read -> rdata 0 with err and `rvalid` together.
